decoder_scan_seq: RTL and testbench

//  Scan sequencer that drives the select/enable inputs of the 2x4 active-low decoder.

---
 rtl/decoder_scan_seq.sv | 187 ++++++++++++++++++
 tb/tb_decoder_scan_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_seq.sv
// ---------------------------------------------------------------------------
// decoder_scan_seq
//   Scan sequencer that drives the en/a/b inputs of a 2x4 active-low decoder.
//   Lines are visited round-robin in ascending index order, skipping lines
//   whose mask bit is clear. Each visit consists of an optional blanking gap
//   (decoder disabled, address already valid) followed by a dwell period
//   with the decoder enabled.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      1-cycle request to begin scanning (only honoured in IDLE)
//   stop       1-cycle request to end scanning after the current line
//   oneshot    1: scan a single frame, 0: scan continuously (taken on start)
//   mask       per-line enable, bit i enables line {a,b}==i
//   dwell      enabled cycles per line (0 behaves as 1)
//   blank      disabled cycles before each line (0 = no gap)
//   en         decoder enable, active-low
//   a, b       line index MSB / LSB
//   busy       high whenever the sequencer is not idle
//   line_done  pulse in the cycle after a line's dwell ends
//   frame_done pulse alongside line_done when the highest enabled line ends
// ---------------------------------------------------------------------------
module decoder_scan_seq #(
   parameter int unsigned DWELL_W = 16,
   parameter int unsigned BLANK_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               oneshot,
   input  logic [3:0]         mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [BLANK_W-1:0] blank,
   output logic               en,
   output logic               a,
   output logic               b,
   output logic               busy,
   output logic               line_done,
   output logic               frame_done
);

   // One shared down-counter serves both phases, so it must hold the wider load.
   localparam int unsigned CW = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    idx, idx_nx;
   logic          stop_pend, stop_pend_nx;
   logic          oneshot_q, oneshot_nx;
   logic          line_done_nx, frame_done_nx;

   logic [1:0]    low_idx;
   logic [1:0]    next_idx;
   logic          any_above;
   logic [CW-1:0] dwell_ld;
   logic [CW-1:0] blank_ld;

   // A zero dwell still gives one enabled cycle.
   assign dwell_ld = (dwell == '0) ? CW'(1) : CW'(dwell);
   assign blank_ld = CW'(blank);

   // Line search: lowest enabled line, and the next enabled line above the
   // current one. When nothing lies above, the search wraps to the lowest
   // line and the current line is the last of the frame.
   always_comb begin
      low_idx   = 2'd0;
      next_idx  = 2'd0;
      any_above = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) begin
            low_idx = 2'(i);
         end
      end
      next_idx = low_idx;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (i > int'(idx))) begin
            next_idx  = 2'(i);
            any_above = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      idx_nx        = idx;
      oneshot_nx    = oneshot_q;
      stop_pend_nx  = stop_pend | (stop && (state != IDLE));
      line_done_nx  = 1'b0;
      frame_done_nx = 1'b0;

      case (state)
         IDLE: begin
            stop_pend_nx = 1'b0;
            if (start && (mask != 4'b0000)) begin
               idx_nx     = low_idx;
               oneshot_nx = oneshot;
               if (blank == '0) begin
                  state_nx = DRIVE;
                  cnt_nx   = dwell_ld;
               end else begin
                  state_nx = BLANK;
                  cnt_nx   = blank_ld;
               end
            end
         end

         BLANK: begin
            // A stop during the gap abandons the line before it is ever enabled.
            if (stop) begin
               state_nx = IDLE;
            end else if (cnt == CW'(1)) begin
               state_nx = DRIVE;
               cnt_nx   = dwell_ld;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end

         DRIVE: begin
            if (cnt <= CW'(1)) begin
               line_done_nx  = 1'b1;
               frame_done_nx = (mask != 4'b0000) && !any_above;
               if (stop_pend_nx || (mask == 4'b0000) || (oneshot_q && !any_above)) begin
                  state_nx = IDLE;
               end else begin
                  idx_nx = next_idx;
                  if (blank == '0) begin
                     state_nx = DRIVE;
                     cnt_nx   = dwell_ld;
                  end else begin
                     state_nx = BLANK;
                     cnt_nx   = blank_ld;
                  end
               end
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      if (state_nx == IDLE) begin
         stop_pend_nx = 1'b0;
      end
   end

   // Outputs are taken from the next-state decode so every port is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= 2'd0;
         stop_pend  <= 1'b0;
         oneshot_q  <= 1'b0;
         en         <= 1'b1;
         busy       <= 1'b0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         stop_pend  <= stop_pend_nx;
         oneshot_q  <= oneshot_nx;
         en         <= (state_nx != DRIVE);
         busy       <= (state_nx != IDLE);
         line_done  <= line_done_nx;
         frame_done <= frame_done_nx;
      end
   end

   assign a = idx[1];
   assign b = idx[0];

endmodule

// File: tb/tb_decoder_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_seq
//   Self-checking bench. A behavioural model expands each scan request into
//   the expected per-cycle output trace {busy,en,a,b,line_done,frame_done},
//   applies any stop request to that trace, and the DUT is compared cycle by
//   cycle against it.
// ---------------------------------------------------------------------------
module tb_decoder_scan_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        oneshot = 1'b0;
   logic [3:0]  mask = 4'b0000;
   logic [15:0] dwell = 16'd1;
   logic [7:0]  blank = 8'd0;
   logic        en, a, b, busy, line_done, frame_done;

   int numChecks = 0;
   int numFails  = 0;

   typedef struct {
      logic [5:0] v;
      bit         drv;
      int         seq;
   } entry_t;

   entry_t trace[$];

   decoder_scan_seq #(.DWELL_W(16), .BLANK_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .oneshot(oneshot),
      .mask(mask),
      .dwell(dwell),
      .blank(blank),
      .en(en),
      .a(a),
      .b(b),
      .busy(busy),
      .line_done(line_done),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] dutVec();
      return {busy, en, a, b, line_done, frame_done};
   endfunction

   task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %b expected %b (busy,en,a,b,ld,fd) at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int highestLine(input logic [3:0] m);
      int h = 0;
      for (int i = 0; i < 4; i++) if (m[i]) h = i;
      return h;
   endfunction

   function automatic int lowestLine(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic void pushEntry(input bit bsy, input bit e, input int line,
                                     input bit ld, input bit fd, input bit drv, input int seq);
      entry_t x;
      x.v   = {bsy, e, 2'(line), ld, fd};
      x.drv = drv;
      x.seq = seq;
      trace.push_back(x);
   endfunction

   // Expected trace for one scan: per line, `blank` disabled cycles then
   // max(dwell,1) enabled cycles; line_done/frame_done ride on the first
   // cycle after the line. Ends with the idle cycle that follows the run.
   function automatic void buildTrace(input logic [3:0] m, input int dw, input int bl,
                                      input bit os, input int maxLen);
      int  line = lowestLine(m);
      int  hi   = highestLine(m);
      int  d    = (dw == 0) ? 1 : dw;
      int  seq  = 0;
      bit  pLd  = 0;
      bit  pFd  = 0;
      trace.delete();
      while (1) begin
         for (int j = 0; j < bl; j++) begin
            pushEntry(1, 1, line, pLd, pFd, 0, seq);
            pLd = 0; pFd = 0;
         end
         for (int j = 0; j < d; j++) begin
            pushEntry(1, 0, line, pLd, pFd, 1, seq);
            pLd = 0; pFd = 0;
         end
         pLd = 1;
         pFd = (line == hi);
         if (os && line == hi) break;
         if (trace.size() >= maxLen) break;
         line = (line + 1) % 4;
         while (!m[line]) line = (line + 1) % 4;
         seq++;
      end
      pushEntry(0, 1, line, pLd, pFd, 0, -1);
   endfunction

   // Stop seen while trace[k] is showing: a gap ends at once, a dwell runs out.
   function automatic void applyStop(input int k, input logic [3:0] m);
      entry_t e;
      int     last;
      if (k < 0 || k >= trace.size()) return;
      e = trace[k];
      if (e.seq < 0) return;
      if (!e.drv) begin
         while (trace.size() > k + 1) void'(trace.pop_back());
         pushEntry(0, 1, int'(e.v[3:2]), 0, 0, 0, -1);
      end else begin
         last = k;
         while (last + 1 < trace.size() && trace[last+1].drv && trace[last+1].seq == e.seq) last++;
         while (trace.size() > last + 1) void'(trace.pop_back());
         pushEntry(0, 1, int'(e.v[3:2]), 1, (int'(e.v[3:2]) == highestLine(m)), 0, -1);
      end
   endfunction

   task automatic applyStimulus(input logic [3:0] m, input int dw, input int bl,
                                input bit os, input int stopK, input string tag);
      logic [5:0] idleV;
      mask    = m;
      dwell   = 16'(dw);
      blank   = 8'(bl);
      oneshot = os;
      buildTrace(m, dw, bl, os, 50);
      applyStop(stopK, m);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < trace.size(); k++) begin
         checkOutput(tag, dutVec(), trace[k].v);
         if (k == trace.size() - 1) break;
         if (k == stopK) stop = 1'b1;
         step();
         stop = 1'b0;
      end
      idleV = {2'b01, trace[trace.size()-1].v[3:2], 2'b00};
      for (int j = 0; j < 3; j++) begin
         step();
         checkOutput({tag, "_idle"}, dutVec(), idleV);
      end
   endtask

   initial begin
      int size0;
      int sk;
      bit os;
      logic [3:0] m;
      int dw, bl;

      // Reset held two cycles, then ten quiet idle cycles.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int j = 0; j < 10; j++) begin
         step();
         checkOutput("reset_idle", dutVec(), 6'b010000);
      end

      // Start with an empty mask is ignored.
      mask  = 4'b0000;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 4; j++) begin
         checkOutput("mask0_start", dutVec(), 6'b010000);
         step();
      end

      // Full mask, continuous, stopped late in the second frame.
      applyStimulus(4'b1111, 3, 1, 0, 27, "cont_full");
      // Sparse mask with no gap, single frame.
      applyStimulus(4'b1010, 2, 0, 1, -1, "oneshot_nogap");
      // Stop in the second cycle of a five-cycle dwell.
      applyStimulus(4'b0011, 5, 2, 0, 3, "stop_in_drive");
      // Stop during a gap.
      applyStimulus(4'b0101, 2, 3, 0, 1, "stop_in_blank");
      // Zero dwell acts as one cycle.
      applyStimulus(4'b0001, 0, 2, 1, -1, "dwell0");
      // Largest gap and a long dwell.
      applyStimulus(4'b1000, 1, 255, 1, -1, "blank_max");
      applyStimulus(4'b0100, 300, 0, 1, -1, "dwell_long");

      // Reset in mid-dwell with a stop pending; a later start must scan past line 1.
      mask = 4'b1111; dwell = 16'd5; blank = 8'd1; oneshot = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("rst_mid_drive", dutVec(), 6'b010000);
      applyStimulus(4'b0110, 2, 1, 0, 10, "after_rst");

      // Randomized scans.
      for (int r = 0; r < 40; r++) begin
         m  = 4'($urandom_range(1, 15));
         dw = $urandom_range(0, 5);
         bl = $urandom_range(0, 3);
         os = 1'($urandom_range(0, 1));
         buildTrace(m, dw, bl, os, 50);
         size0 = trace.size();
         if (os) begin
            sk = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, size0 - 1);
         end else begin
            sk = $urandom_range(0, size0 - 2);
         end
         applyStimulus(m, dw, bl, os, sk, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
